// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared M-extension funct3 codes and muldiv FSM encodings
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring divide iteration
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              div,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] r_ext;
  logic [XLEN:0] diff;

  // acc = {hi, lo}: multiply shifts right adding into hi; divide shifts
  // the partial remainder left and sets a quotient bit in lo on success.
  always_comb begin
    sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    r_ext = acc[2*XLEN-1:XLEN-1];
    diff  = r_ext - {1'b0, operand};
    if (div) begin
      if (diff[XLEN])
        acc_next = {r_ext[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative RV32M multiply/divide unit with pipeline stall
module muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            iclk,
  input  logic            irst,
  input  logic            istart,
  input  logic [2:0]      ifunct3,
  input  logic [XLEN-1:0] ia,
  input  logic [XLEN-1:0] ib,
  input  logic            iflush,
  output logic            ostall,
  output logic            ovalid,
  output logic [XLEN-1:0] oresult
);

  localparam logic [5:0] LAST = 6'(XLEN - 1);

  logic [1:0]        state;
  logic [5:0]        cnt;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   opb;

  logic              a_sgn, b_sgn, sa, sb, is_div, is_rem, div_zero, ovf, neg_start;
  logic [XLEN-1:0]   a_mag, b_mag, short_res, fix_res;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  always_comb begin
    a_sgn    = !(ifunct3 == F3_MULHU || ifunct3 == F3_DIVU || ifunct3 == F3_REMU);
    b_sgn    = (ifunct3 == F3_MUL || ifunct3 == F3_MULH || ifunct3 == F3_DIV || ifunct3 == F3_REM);
    sa       = a_sgn & ia[XLEN-1];
    sb       = b_sgn & ib[XLEN-1];
    a_mag    = sa ? -ia : ia;
    b_mag    = sb ? -ib : ib;
    is_div   = ifunct3[2];
    is_rem   = ifunct3[2] & ifunct3[1];
    div_zero = is_div && (ib == '0);
    ovf      = (ifunct3 == F3_DIV || ifunct3 == F3_REM) &&
               (ia == {1'b1, {(XLEN-1){1'b0}}}) && (ib == '1);
    // Remainder follows the dividend sign; everything else takes the xor.
    neg_start = (ifunct3 == F3_REM) ? sa : (sa ^ sb);
    if (div_zero)
      short_res = is_rem ? ia : '1;
    else
      short_res = is_rem ? '0 : ia;
  end

  always_comb begin
    prod_s = neg_q ? -acc : acc;
    quo_s  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_s  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:                       fix_res = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res = quo_s;
      F3_REM, F3_REMU:              fix_res = rem_s;
      default:                      fix_res = '0;
    endcase
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc      (acc),
    .operand  (opb),
    .div      (f3_q[2]),
    .acc_next (acc_next)
  );

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      acc     <= '0;
      opb     <= '0;
      oresult <= '0;
    end else if (iflush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (istart) begin
          f3_q  <= ifunct3;
          neg_q <= neg_start;
          acc   <= {{XLEN{1'b0}}, a_mag};
          opb   <= b_mag;
          cnt   <= '0;
          if (div_zero || ovf) begin
            oresult <= short_res;
            state   <= S_DONE;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          oresult <= fix_res;
          state   <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ostall = ~irst & ((state == S_IDLE & istart & ~iflush) |
                           (state == S_CALC) | (state == S_FIX));
  assign ovalid = (state == S_DONE) & ~iflush;

endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - directed self-checking bench for muldiv
module tb_muldiv;
  import muldiv_pkg::*;

  logic        iclk;
  logic        irst;
  logic        istart;
  logic [2:0]  ifunct3;
  logic [31:0] ia;
  logic [31:0] ib;
  logic        iflush;
  logic        ostall;
  logic        ovalid;
  logic [31:0] oresult;

  int compared;
  int mismatched;
  int seen;

  muldiv #(.XLEN(32)) dut (
    .iclk    (iclk),
    .irst    (irst),
    .istart  (istart),
    .ifunct3 (ifunct3),
    .ia      (ia),
    .ib      (ib),
    .iflush  (iflush),
    .ostall  (ostall),
    .ovalid  (ovalid),
    .oresult (oresult)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Start in the cycle after the next rising edge (cycle N = index 0),
  // scramble operands afterwards, and measure latency / stall cycles.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int stall_cnt;
    logic [31:0] res;
    logic stall_at_done;
    lat = -1;
    stall_cnt = 0;
    res = '0;
    stall_at_done = 1'b1;
    @(posedge iclk); #1;
    istart = 1'b1; ifunct3 = f3; ia = a; ib = b;
    for (int k = 0; k < 60; k++) begin
      @(negedge iclk);
      if (ostall) stall_cnt++;
      if (ovalid) begin
        lat = k;
        res = oresult;
        stall_at_done = ostall;
        break;
      end
      @(posedge iclk); #1;
      if (k == 0) begin
        istart = 1'b0;
        ia = $urandom;
        ib = $urandom;
        ifunct3 = 3'($urandom_range(0, 7));
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, res, exp_res);
    check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
    check({tag, "_stall_done"}, {31'd0, stall_at_done}, 32'd0);
    @(posedge iclk); #1;
    @(negedge iclk);
    check({tag, "_valid_once"}, {31'd0, ovalid}, 32'd0);
    check({tag, "_hold"}, oresult, exp_res);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    irst = 1'b0; istart = 1'b0; ifunct3 = '0; ia = '0; ib = '0; iflush = 1'b0;
    #2 irst = 1'b1;
    #1;
    check("rst_valid", {31'd0, ovalid}, 32'd0);
    check("rst_stall", {31'd0, ostall}, 32'd0);
    check("rst_result", oresult, 32'd0);
    check("rst_state", {30'd0, dut.state}, {30'd0, S_IDLE});
    repeat (2) @(posedge iclk);
    #1 irst = 1'b0;

    run_op("mul_neg",   F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("mulhu_max", F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("mulh_m1",   F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
    run_op("mulhsu_m1", F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run_op("div_neg",   F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    run_op("rem_neg",   F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    run_op("div_negb",  F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    run_op("rem_negb",  F3_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 34);
    run_op("divu",      F3_DIVU,   32'd100,      32'd7,        32'd14,       34);
    run_op("remu",      F3_REMU,   32'd100,      32'd7,        32'd2,        34);
    run_op("divu_zero", F3_DIVU,   32'd55,       32'd0,        32'hFFFFFFFF, 1);
    run_op("remu_zero", F3_REMU,   32'h1234,     32'd0,        32'h00001234, 1);
    run_op("div_zero",  F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("div_ovf",   F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",   F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Flush a DIVU at cycle N+10, then restart at N+12.
    seen = 0;
    @(posedge iclk); #1;
    istart = 1'b1; ifunct3 = F3_DIVU; ia = 32'd1000; ib = 32'd3;
    for (int k = 1; k <= 11; k++) begin
      @(posedge iclk); #1;
      if (k == 1) istart = 1'b0;
      if (k == 10) iflush = 1'b1;
      if (k == 11) iflush = 1'b0;
      @(negedge iclk);
      if (ovalid) seen++;
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    check("flush_state", {30'd0, dut.state}, {30'd0, S_IDLE});
    check("flush_stall", {31'd0, ostall}, 32'd0);
    run_op("after_flush", F3_DIVU, 32'd1000, 32'd3, 32'd333, 34);

    // Asynchronous reset in the middle of CALC.
    @(posedge iclk); #1;
    istart = 1'b1; ifunct3 = F3_MUL; ia = 32'd5; ib = 32'd6;
    for (int k = 1; k <= 10; k++) begin
      @(posedge iclk); #1;
      if (k == 1) istart = 1'b0;
    end
    @(negedge iclk);
    check("midcalc_stall", {31'd0, ostall}, 32'd1);
    #2 irst = 1'b1;
    #1;
    check("arst_valid", {31'd0, ovalid}, 32'd0);
    check("arst_stall", {31'd0, ostall}, 32'd0);
    check("arst_result", oresult, 32'd0);
    check("arst_state", {30'd0, dut.state}, {30'd0, S_IDLE});
    check("arst_cnt", {26'd0, dut.cnt}, 32'd0);
    @(posedge iclk); #1 irst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge iclk);
      if (ovalid || ostall) seen++;
    end
    check("post_rst_quiet", 32'(seen), 32'd0);
    check("post_rst_idle", {30'd0, dut.state}, {30'd0, S_IDLE});
    run_op("post_rst_mul", F3_MUL, 32'd5, 32'd6, 32'd30, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
